serial_comparator_ctrl: RTL and testbench
=========================================

// Module: serial_comparator_ctrl
// PURPOSE
//   Sequences one shared 2-bit comparator slice to compare two WIDTH-bit unsigned
//   operands, two bits per cycle, MSB pair first. Accepts a compare request through a
//   start/ready handshake, then returns g/l flags with a one-cycle done pulse.
//   Used wherever a wide magnitude compare is needed at minimal area (one slice, shifting operands).
// PARAMETERS
//   WIDTH   8   operand width in bits; must be even and >= 2; slice count NS = WIDTH/2
//   CNT_W   derived: max(1, $clog2(NS)); width of the slice counter (localparam, not overridable)
// PORTS
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous reset, active-high
//   start   in   1      request; accepted on a clk edge where start & ready
//   a       in   WIDTH  operand A, sampled only on accept
//   b       in   WIDTH  operand B, sampled only on accept
//   ready   out  1      high only in IDLE (combinational decode of state)
//   done    out  1      one-cycle pulse: g/l hold the result of the accepted request
//   g       out  1      registered; 1 iff A > B
//   l       out  1      registered; 1 iff A < B (g=l=0 means A == B; g=l=1 never occurs)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, ready=1, done=0, g=0, l=0, shift regs and counter = 0.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on start: load A/B shift regs, cnt = NS-1, clear sticky result, go to RUN.
//   RUN: the slice compares the shift-reg bits [WIDTH-1:WIDTH-2]. Slice: sg = A>B, sl = A<B (2-bit).
//     The first slice with sg|sl sets the sticky result. Later slices never overwrite it.
//     Exit to DONE when cnt==0 (or early, see CONFIGURATION). Otherwise shift both regs
//     left by 2 (zero fill) and decrement cnt.
//   DONE: done=1 for exactly this cycle. g/l are updated on the RUN->DONE edge from the
//     sticky result (or the deciding slice) and hold until the next RUN->DONE edge.
//     The state then returns to IDLE unconditionally.
//   Latency: accept on edge T. RUN covers cycles T+1..T+NS. done is high in cycle T+NS+1.
//     The next accept is possible at edge T+NS+2.
//   start while ready=0 (RUN/DONE) is ignored and not queued. a/b changes after accept
//     have no effect.
//   rst mid-RUN/DONE: operation aborted, no done pulse, g=l=0.
//   WIDTH=2: NS=1, RUN lasts exactly one cycle.
// CONFIGURATION
//   SERIAL_CMP_EARLY_EXIT_EN defined:
//     RUN exits to DONE on the first slice with sg|sl. Latency for a decision at slice i
//     (0 = MSB pair) is done in cycle T+i+2. Equal operands still take the full T+NS+1.
//   Not defined: constant time. RUN always lasts NS cycles. The result is the first
//     deciding slice, latched sticky.
//   g/l values are identical in both builds. Only done timing differs.
// STRUCTURE
//   Shared package comparator_pkg holds:
//     - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//     - result encoding constants CMP_EQ=2'b00, CMP_GT=2'b10, CMP_LT=2'b01 ({g,l})
//   Sub-module comparator_slice (a[1:0], b[1:0] -> g, l) is purely combinational,
//     built from gate primitives, and instantiated once.
//   This module holds the FSM, the counter, the two shift registers and the sticky result.
// TESTING (WIDTH=8; run both with and without SERIAL_CMP_EARLY_EXIT_EN)
//   1. Assert rst mid-cycle, no clock edge -> immediately ready=1, done=0, g=0, l=0.
//   2. Send A=0xA5, B=0xA5 -> done in cycle T+5, g=0, l=0 in both builds.
//   3. Send A=0x80, B=0x7F -> g=1, l=0. done at T+2 with the macro, at T+5 without.
//   4. Send A=0x12, B=0x13 -> l=1, g=0, done at T+5 in both builds.
//      Then A=0x13, B=0x12 -> g=1, l=0.
//   5. Hold start high continuously with changing a/b -> one accept per
//      IDLE (ready=0 in RUN/DONE). Each result matches the operands sampled at accept.
//      g/l stay stable between done pulses.
//   6. Send A=0x01, B=0x00, assert rst at T+2 -> no done pulse, g=l=0, ready=1.
//      A new request is then accepted normally and completes correctly.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states and {g,l} result codes.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result codes packed as {g,l}
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b10;
  localparam logic [1:0] CMP_LT = 2'b01;

endpackage

// File: rtl/comparator_slice.sv
// Two-bit unsigned magnitude compare slice built from gate primitives.
// g = (a > b), l = (a < b); both low when the pairs are equal.
module comparator_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       g,
  output logic       l
);

  logic na1, na0, nb1, nb0;
  logic eq1;
  logic g_hi, g_lo, l_hi, l_lo;

  not u_na1 (na1, a[1]);
  not u_na0 (na0, a[0]);
  not u_nb1 (nb1, b[1]);
  not u_nb0 (nb0, b[0]);

  // The low bit only matters when the high bits agree
  xnor u_eq1 (eq1, a[1], b[1]);

  and u_ghi (g_hi, a[1], nb1);
  and u_glo (g_lo, eq1, a[0], nb0);
  or  u_g   (g, g_hi, g_lo);

  and u_lhi (l_hi, na1, b[1]);
  and u_llo (l_lo, eq1, na0, b[0]);
  or  u_l   (l, l_hi, l_lo);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Serial WIDTH-bit unsigned magnitude comparator: one shared 2-bit slice walks the
// operands MSB pair first, one pair per cycle, and reports {g,l} with a done pulse.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN -- leave RUN on the first deciding
// slice instead of always running all WIDTH/2 slices. Results are identical either way.
//
// Handshake: a request is accepted on a rising clk edge where start & ready are both
// high; ready is high only in IDLE, so start is ignored (not queued) while busy.
// done is high for exactly one cycle; g/l are registered and hold until the next result.
module serial_comparator_ctrl
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             g,
  output logic             l
);

  localparam int NS    = WIDTH / 2;
  localparam int CNT_W = (NS > 1) ? $clog2(NS) : 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sa, sb;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         sticky;
  logic               slice_g, slice_l;
  logic               decided;
  logic               last;
  logic [1:0]         res_now;
  logic               load, step, finish;

  comparator_slice u_slice (
    .a (sa[WIDTH-1:WIDTH-2]),
    .b (sb[WIDTH-1:WIDTH-2]),
    .g (slice_g),
    .l (slice_l)
  );

  assign decided = slice_g | slice_l;

  // The first deciding slice wins; later slices can never override it
  assign res_now = (sticky != CMP_EQ) ? sticky : {slice_g, slice_l};

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign last = (cnt == '0) || decided;
`else
  assign last = (cnt == '0);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and control strobes
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand shift registers, slice counter, sticky result and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      sticky <= CMP_EQ;
      g      <= 1'b0;
      l      <= 1'b0;
    end else begin
      if (load) begin
        sa     <= a;
        sb     <= b;
        cnt    <= CNT_W'(NS - 1);
        sticky <= CMP_EQ;
      end
      if (step) begin
        sa  <= sa << 2;
        sb  <= sb << 2;
        cnt <= cnt - CNT_W'(1);
        if (sticky == CMP_EQ) sticky <= {slice_g, slice_l};
      end
      if (finish) begin
        g <= res_now[1];
        l <= res_now[0];
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Bench for serial_comparator_ctrl (WIDTH=8). Accepted requests are scored against a
// plain-arithmetic model of the compare result and of the done cycle; a monitor on the
// falling edge pops and compares every done pulse. Build with or without
// SERIAL_CMP_EARLY_EXIT_EN; the latency model follows the same macro.
module tb_serial_comparator_ctrl;

  localparam int W  = 8;
  localparam int NS = W / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start;
  logic [W-1:0] a, b;
  logic         ready, done, g, l;

  serial_comparator_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .g     (g),
    .l     (l)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  logic [1:0] exp_q[$];
  int         due_q[$];
  logic [1:0] prev_gl = 2'b00;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_gl(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x > y)      return 2'b10;
    else if (x < y) return 2'b01;
    else            return 2'b00;
  endfunction

  // Cycles from the accept cycle to the cycle where done is high
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = 0; i < NS; i++) begin
      if (x[W-1-2*i -: 2] != y[W-1-2*i -: 2]) return i + 2;
    end
`endif
    return NS + 1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      prev_gl = 2'b00;
    end else if (armed) begin
      check("ready", int'(ready), int'(exp_q.size() == 0));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          logic [1:0] e;
          int         d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          check("result_gl", int'({g, l}), int'(e));
          check("done_cycle", cyc, d);
          prev_gl = {g, l};
        end
      end else begin
        check("gl_hold", int'({g, l}), int'(prev_gl));
      end
      if (start && ready) begin
        exp_q.push_back(ref_gl(a, b));
        due_q.push_back(cyc + ref_lat(a, b));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("ready_timeout", 0, 1);
    start = 1'b1;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !ready) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Asynchronous reset applied mid-cycle, observed before any edge
    #13;
    rst = 1'b1;
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_done",  int'(done),  0);
    check("rst_g",     int'(g),     0);
    check("rst_l",     int'(l),     0);
    tick();
    tick();
    rst   = 1'b0;
    armed = 1'b1;
    tick();

    // Directed operand pairs
    send(8'hA5, 8'hA5); wait_idle();
    send(8'h80, 8'h7F); wait_idle();
    send(8'h12, 8'h13); wait_idle();
    send(8'h13, 8'h12); wait_idle();
    send(8'hFF, 8'h00); wait_idle();
    send(8'h00, 8'hFF); wait_idle();
    send(8'h00, 8'h00); wait_idle();
    send(8'hFE, 8'hFF); wait_idle();

    // start held high with operands changing every cycle
    for (int i = 0; i < 40; i++) begin
      start = 1'b1;
      a     = W'($urandom);
      b     = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      tick();
    end
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a compare aborts it
    send(8'h01, 8'h00);
    tick();
    rst = 1'b1;
    #1;
    check("abort_ready", int'(ready), 1);
    check("abort_done",  int'(done),  0);
    check("abort_gl",    int'({g, l}), 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    send(8'h5C, 8'h5D); wait_idle();

    // Randomized traffic, biased toward operands that differ late or not at all
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      case ($urandom_range(0, 2))
        0:       y = x;
        1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
        default: y = W'($urandom);
      endcase
      send(x, y);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
